// File: rtl/regfile_wr_arbiter_if.sv
// Write-request bus between the three requesters and the register-bank write arbiter,
// plus the registered write-port outputs that drive the bank.
interface regfile_wr_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic          stall;
   logic [2:0]    req_valid;
   logic [AW-1:0] req_addr0;
   logic [AW-1:0] req_addr1;
   logic [AW-1:0] req_addr2;
   logic [DW-1:0] req_data0;
   logic [DW-1:0] req_data1;
   logic [DW-1:0] req_data2;
   logic [2:0]    req_ready;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic [1:0]    grant_id;
   logic [7:0]    drop_cnt;

   modport master (
      output stall, req_valid, req_addr0, req_addr1, req_addr2,
             req_data0, req_data1, req_data2,
      input  req_ready, rf_we, rf_wa, rf_wd, grant_id, drop_cnt
   );

   modport slave (
      input  stall, req_valid, req_addr0, req_addr1, req_addr2,
             req_data0, req_data1, req_data2,
      output req_ready, rf_we, rf_wa, rf_wd, grant_id, drop_cnt
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among three requesters.
// Optional RFARB_WB_PRIO_EN: requester 0 (CPU writeback) gets absolute priority.
module regfile_wr_arbiter #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wr_arbiter_if.slave  bus
);
   logic [AW-1:0] addr_arr [3];
   logic [DW-1:0] data_arr [3];
   logic [1:0]    last_reg;
   logic [1:0]    win;
   logic          found;
   logic          grant_en;
   logic [2:0]    ready;

   logic          rf_we_reg;
   logic [AW-1:0] rf_wa_reg;
   logic [DW-1:0] rf_wd_reg;
   logic [1:0]    grant_id_reg;
   logic [7:0]    drop_cnt_reg;

   assign addr_arr[0] = bus.req_addr0;
   assign addr_arr[1] = bus.req_addr1;
   assign addr_arr[2] = bus.req_addr2;
   assign data_arr[0] = bus.req_data0;
   assign data_arr[1] = bus.req_data1;
   assign data_arr[2] = bus.req_data2;

   // (base + off) mod 3 for base in 0..2, off in 1..3
   function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 3'd3)
         sum = sum - 3'd3;
      return sum[1:0];
   endfunction

   always_comb begin
      win   = 2'd0;
      found = 1'b0;
`ifdef RFARB_WB_PRIO_EN
      if (bus.req_valid[0]) begin
         win   = 2'd0;
         found = 1'b1;
      end else if (last_reg == 2'd1) begin
         if (bus.req_valid[2]) begin
            win   = 2'd2;
            found = 1'b1;
         end else if (bus.req_valid[1]) begin
            win   = 2'd1;
            found = 1'b1;
         end
      end else begin
         if (bus.req_valid[1]) begin
            win   = 2'd1;
            found = 1'b1;
         end else if (bus.req_valid[2]) begin
            win   = 2'd2;
            found = 1'b1;
         end
      end
`else
      // Scan from lowest priority upward so the first valid in rotation order wins last.
      for (int k = 3; k >= 1; k--) begin
         if (bus.req_valid[rr_step(last_reg, 2'(k))]) begin
            win   = rr_step(last_reg, 2'(k));
            found = 1'b1;
         end
      end
`endif
   end

   assign grant_en = reset && !bus.stall && found;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ready
         assign ready[gi] = grant_en && (win == 2'(gi));
      end
   endgenerate

   assign bus.req_ready = ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rf_we_reg    <= 1'b0;
         rf_wa_reg    <= '0;
         rf_wd_reg    <= '0;
         grant_id_reg <= 2'd0;
         drop_cnt_reg <= 8'd0;
         last_reg     <= 2'd2;
      end else begin
         rf_we_reg <= 1'b0;
         if (grant_en) begin
`ifdef RFARB_WB_PRIO_EN
            if (win != 2'd0)
               last_reg <= win;
`else
            last_reg <= win;
`endif
            grant_id_reg <= win;
            rf_wa_reg    <= addr_arr[win];
            rf_wd_reg    <= data_arr[win];
            // Register 0 is hardwired to zero: acknowledge the write but never pass it on.
            if (addr_arr[win] != '0)
               rf_we_reg <= 1'b1;
            else if (drop_cnt_reg != 8'hFF)
               drop_cnt_reg <= drop_cnt_reg + 8'd1;
         end
      end
   end

   assign bus.rf_we    = rf_we_reg;
   assign bus.rf_wa    = rf_wa_reg;
   assign bus.rf_wd    = rf_wd_reg;
   assign bus.grant_id = grant_id_reg;
   assign bus.drop_cnt = drop_cnt_reg;
endmodule
